// File: rtl/snake_pkg.sv
// Shared playfield geometry and FSM state encoding for the snake game blocks.
package snake_pkg;

  localparam int unsigned WIDTH           = 32;
  localparam int unsigned HEIGHT          = 24;
  localparam int unsigned CELLS           = WIDTH * HEIGHT;
  localparam int unsigned NUM_LEN         = 10;
  localparam int unsigned MAX_LEN         = 16;
  localparam int unsigned MAX_LEN_BIT_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    CHECK,
    COMMIT
  } state_t;

endpackage

// File: rtl/food_spawner_lfsr10.sv
// 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1, with load-on-reset seed.
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] q
);

  // Shift left, feeding back taps 10 and 7; a nonzero seed never reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[8:0], q[9] ^ q[6]};
    end
  end

endmodule

// File: rtl/food_spawner.sv
// Searches for a new food cell inside the playfield that avoids the snake
// body, the other player's food and the old food; random draws first, then
// a linear scan once the try budget is spent.
module food_spawner #(
  parameter int unsigned WIDTH           = snake_pkg::WIDTH,
  parameter int unsigned HEIGHT          = snake_pkg::HEIGHT,
  parameter int unsigned NUM_LEN         = snake_pkg::NUM_LEN,
  parameter int unsigned MAX_LEN         = snake_pkg::MAX_LEN,
  parameter int unsigned MAX_LEN_BIT_LEN = snake_pkg::MAX_LEN_BIT_LEN,
  parameter int unsigned MAX_TRIES       = 32,
  parameter logic [9:0]  SEED            = 10'h2A5,
  parameter int unsigned FOOD_INIT       = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic [MAX_LEN*NUM_LEN-1:0]   snake_body,
  input  logic [MAX_LEN_BIT_LEN:0]     snake_len,
  input  logic [NUM_LEN-1:0]           other_food,
  output logic [NUM_LEN-1:0]           food,
  output logic                         busy,
  output logic                         done
);
  import snake_pkg::*;

  localparam int unsigned             CELLS   = WIDTH * HEIGHT;
  localparam logic [NUM_LEN:0]        CELLS_W = (NUM_LEN+1)'(CELLS);
  localparam int unsigned             TRY_W   = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0]        TRY_LIM = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0]        TRY_SAT = '1;
  localparam logic [MAX_LEN_BIT_LEN:0] LEN_MAX = (MAX_LEN_BIT_LEN+1)'(MAX_LEN);

  state_t                       state_q, state_d;
  logic [MAX_LEN*NUM_LEN-1:0]   body_q, body_d;
  logic [MAX_LEN_BIT_LEN:0]     len_q, len_d;
  logic [NUM_LEN-1:0]           other_q, other_d;
  logic [NUM_LEN-1:0]           old_q, old_d;
  logic [NUM_LEN-1:0]           cand_q, cand_d;
  logic [TRY_W-1:0]             try_q, try_d;
  logic                         fb_q, fb_d;
  logic [MAX_LEN_BIT_LEN-1:0]   seg_q, seg_d;
  logic [NUM_LEN-1:0]           food_q, food_d;
  logic                         busy_q, busy_d;
  logic                         done_pend_q, done_pend_d;
  logic                         done_q;

  logic [9:0]                   lfsr_q;
  logic [NUM_LEN:0]             cand_sum;
  logic [NUM_LEN-1:0]           cand_next_lin;
  logic [NUM_LEN-1:0]           draw_cand;
  logic                         draw_bad;
  logic [NUM_LEN-1:0]           seg_val;
  logic                         seg_last;
  logic [TRY_W-1:0]             try_inc;

  lfsr10 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .en (1'b1),
    .q  (lfsr_q)
  );

  // Next-state, candidate generation and per-segment collision check.
  always_comb begin
    state_d     = state_q;
    body_d      = body_q;
    len_d       = len_q;
    other_d     = other_q;
    old_d       = old_q;
    cand_d      = cand_q;
    try_d       = try_q;
    fb_d        = fb_q;
    seg_d       = seg_q;
    food_d      = food_q;
    busy_d      = busy_q;
    done_pend_d = 1'b0;

    cand_sum      = {1'b0, cand_q} + 1'b1;
    cand_next_lin = (cand_sum >= CELLS_W) ? '0 : cand_sum[NUM_LEN-1:0];
    draw_cand     = fb_q ? cand_next_lin : NUM_LEN'(lfsr_q);
    draw_bad      = (!fb_q && ({1'b0, draw_cand} >= CELLS_W)) ||
                    (draw_cand == other_q) || (draw_cand == old_q);
    seg_val       = body_q[int'(seg_q)*NUM_LEN +: NUM_LEN];
    seg_last      = ({1'b0, seg_q} == (len_q - 1'b1));
    try_inc       = (try_q == TRY_SAT) ? try_q : try_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          body_d  = snake_body;
          len_d   = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;
          other_d = other_food;
          old_d   = food_q;
          busy_d  = 1'b1;
          try_d   = '0;
          fb_d    = 1'b0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        // Rejected candidates are still kept: the linear scan continues from them.
        cand_d = draw_cand;
        if (draw_bad) begin
          try_d = try_inc;
          fb_d  = fb_q | (try_inc >= TRY_LIM);
        end else if (len_q == '0) begin
          state_d = COMMIT;
        end else begin
          seg_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (seg_val == cand_q) begin
          try_d   = try_inc;
          fb_d    = fb_q | (try_inc >= TRY_LIM);
          state_d = DRAW;
        end else if (seg_last) begin
          state_d = COMMIT;
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
      COMMIT: begin
        food_d      = cand_q;
        busy_d      = 1'b0;
        done_pend_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; done trails the food update by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      body_q      <= '0;
      len_q       <= '0;
      other_q     <= '0;
      old_q       <= '0;
      cand_q      <= '0;
      try_q       <= '0;
      fb_q        <= 1'b0;
      seg_q       <= '0;
      food_q      <= NUM_LEN'(FOOD_INIT);
      busy_q      <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      body_q      <= body_d;
      len_q       <= len_d;
      other_q     <= other_d;
      old_q       <= old_d;
      cand_q      <= cand_d;
      try_q       <= try_d;
      fb_q        <= fb_d;
      seg_q       <= seg_d;
      food_q      <= food_d;
      busy_q      <= busy_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_pend_q;
    end
  end

  assign food = food_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
